// File: rtl/dispatch_stage_pkg.sv
// Shared instruction layout for the dispatch stage and the issue queue it feeds.
// Input uop is {UOP, BrM, Tag, prd, pr2, pr1}; the queue format appends {val, p2, p1}.
package dispatch_stage_pkg;

    localparam int UOP_W  = 7;
    localparam int STAT_W = 3;
    localparam int SLOTS  = 4;
    localparam int LANES  = 4;

    localparam int P1_BIT  = 0;
    localparam int P2_BIT  = 1;
    localparam int VAL_BIT = 2;

    typedef struct packed {
        logic val;
        logic p2;
        logic p1;
    } stat_t;

    function automatic int inst_in_width(input int wr, input int wt, input int wb);
        return UOP_W + wb + wt + 3 * wr;
    endfunction

    function automatic int pr1_lsb(input int wr);
        return 0 * wr;
    endfunction

    function automatic int pr2_lsb(input int wr);
        return wr;
    endfunction

    function automatic int prd_lsb(input int wr);
        return 2 * wr;
    endfunction

    function automatic int brm_lsb(input int wr, input int wt);
        return 3 * wr + wt;
    endfunction

endpackage

// File: rtl/dispatch_stage_busy.sv
// Physical-register busy table: 8 read ports with writeback bypass,
// 4 clear (writeback) ports, 4 set (allocation) ports; flush > set > clear.
module dispatch_stage_busy
    import dispatch_stage_pkg::*;
#(
    parameter int WIDTH_REG = 6
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [7:0][WIDTH_REG-1:0]           i_rd_addr,
    output logic [7:0]                          o_rd_ready,
    input  logic [LANES-1:0][WIDTH_REG-1:0]     i_clr_addr,
    input  logic [SLOTS-1:0][WIDTH_REG-1:0]     i_set_addr,
    input  logic [SLOTS-1:0]                    i_set_en,
    input  logic                                i_flush
);

    localparam int NREG = 1 << WIDTH_REG;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        // NOTE: start from a full default so no path through the loops leaves busy_nxt unassigned (no latch).
        busy_nxt = busy;
        for (int l = 0; l < LANES; l++)
            if (i_clr_addr[l] != '0) busy_nxt[i_clr_addr[l]] = 1'b0;
        for (int s = 0; s < SLOTS; s++)
            if (i_set_en[s] && i_set_addr[s] != '0) busy_nxt[i_set_addr[s]] = 1'b1;
        if (i_flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // NOTE: the table is plain flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    always_comb begin
        o_rd_ready = '0;
        for (int p = 0; p < 8; p++) begin
            o_rd_ready[p] = (i_rd_addr[p] == '0) || !busy[i_rd_addr[p]];
            for (int l = 0; l < LANES; l++)
                if (i_clr_addr[l] != '0 && i_clr_addr[l] == i_rd_addr[p]) o_rd_ready[p] = 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: readiness from busy table + wakeup, intra-packet dependency
// override, and a held output packet with in-place wakeup, branch kill and stall.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter  int WIDTH_REG = 6,
    parameter  int WIDTH_TAG = 5,
    parameter  int WIDTH_BRM = 4,
    localparam int WIDTH_IN  = inst_in_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM),
    localparam int WIDTH     = WIDTH_IN + STAT_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [WIDTH_IN-1:0]          i_inst1,
    input  logic [WIDTH_IN-1:0]          i_inst2,
    input  logic [WIDTH_IN-1:0]          i_inst3,
    input  logic [WIDTH_IN-1:0]          i_inst4,
    input  logic [3:0]                   i_valid,
    input  logic                         i_en,
    input  logic                         i_stall,
    input  logic [4*WIDTH_REG-1:0]       i_wdest4x,
    input  logic [WIDTH_BRM-1:0]         i_BrKill,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_inst1,
    output logic [WIDTH-1:0]             o_inst2,
    output logic [WIDTH-1:0]             o_inst3,
    output logic [WIDTH-1:0]             o_inst4,
    output logic                         o_en,
    output logic                         o_ready
);

    localparam int PR1_LSB = pr1_lsb(WIDTH_REG);
    localparam int PR2_LSB = pr2_lsb(WIDTH_REG);
    localparam int PRD_LSB = prd_lsb(WIDTH_REG);
    localparam int BRM_LSB = brm_lsb(WIDTH_REG, WIDTH_TAG);

    function automatic logic wake_hit(input logic [WIDTH_REG-1:0] r,
                                      input logic [4*WIDTH_REG-1:0] wd);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < LANES; l++)
            if (wd[l*WIDTH_REG +: WIDTH_REG] != '0 && wd[l*WIDTH_REG +: WIDTH_REG] == r) hit = 1'b1;
        return hit;
    endfunction

    logic [SLOTS-1:0][WIDTH_IN-1:0]  in_inst;
    logic [SLOTS-1:0][WIDTH_REG-1:0] in_pr1, in_pr2, in_prd;
    logic [SLOTS-1:0][WIDTH_BRM-1:0] in_brm;
    logic [SLOTS-1:0]                dep1, dep2;
    logic [7:0][WIDTH_REG-1:0]       rd_addr;
    logic [7:0]                      rd_ready;
    logic [LANES-1:0][WIDTH_REG-1:0] clr_addr;
    logic                            acc;

    logic [SLOTS-1:0][WIDTH_IN-1:0]  held_inst;
    stat_t [SLOTS-1:0]               held_stat;
    stat_t [SLOTS-1:0]               out_stat;
    logic                            en_q;

    assign in_inst  = {i_inst4, i_inst3, i_inst2, i_inst1};
    assign clr_addr = i_wdest4x;
    assign o_en     = en_q;
    assign o_ready  = ~(en_q & i_stall);
    assign acc      = i_en & o_ready & ~i_flush;

    always_comb begin
        in_pr1 = '0;
        in_pr2 = '0;
        in_prd = '0;
        in_brm = '0;
        for (int k = 0; k < SLOTS; k++) begin
            in_pr1[k] = in_inst[k][PR1_LSB +: WIDTH_REG];
            in_pr2[k] = in_inst[k][PR2_LSB +: WIDTH_REG];
            in_prd[k] = in_inst[k][PRD_LSB +: WIDTH_REG];
            in_brm[k] = in_inst[k][BRM_LSB +: WIDTH_BRM];
            rd_addr[k]         = in_pr1[k];
            rd_addr[SLOTS + k] = in_pr2[k];
        end
    end

    // An older valid slot writing a source register makes that source not-ready,
    // regardless of busy state or a same-cycle writeback of the old value.
    always_comb begin
        dep1 = '0;
        dep2 = '0;
        for (int k = 0; k < SLOTS; k++)
            for (int j = 0; j < SLOTS; j++)
                if (j < k && i_valid[j] && in_prd[j] != '0) begin
                    if (in_prd[j] == in_pr1[k]) dep1[k] = 1'b1;
                    if (in_prd[j] == in_pr2[k]) dep2[k] = 1'b1;
                end
    end

    dispatch_stage_busy #(.WIDTH_REG(WIDTH_REG)) u_busy (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_addr  (rd_addr),
        .o_rd_ready (rd_ready),
        .i_clr_addr (clr_addr),
        .i_set_addr (in_prd),
        .i_set_en   (i_valid & {SLOTS{acc}}),
        .i_flush    (i_flush)
    );

    // The presented status folds in this cycle's wakeup and kill; holding a
    // packet re-registers exactly that view.
    always_comb begin
        out_stat = '0;
        for (int k = 0; k < SLOTS; k++) begin
            out_stat[k].val = held_stat[k].val &
                              ~|(held_inst[k][BRM_LSB +: WIDTH_BRM] & i_BrKill);
            out_stat[k].p2  = held_stat[k].p2 |
                              wake_hit(held_inst[k][PR2_LSB +: WIDTH_REG], i_wdest4x);
            out_stat[k].p1  = held_stat[k].p1 |
                              wake_hit(held_inst[k][PR1_LSB +: WIDTH_REG], i_wdest4x);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_q      <= 1'b0;
            held_inst <= '0;
            held_stat <= '0;
        end else if (i_flush) begin
            en_q <= 1'b0;
        end else if (acc) begin
            en_q      <= 1'b1;
            held_inst <= in_inst;
            for (int k = 0; k < SLOTS; k++) begin
                held_stat[k].val <= i_valid[k] & ~|(in_brm[k] & i_BrKill);
                held_stat[k].p2  <= rd_ready[SLOTS + k] & ~dep2[k];
                held_stat[k].p1  <= rd_ready[k] & ~dep1[k];
            end
        end else if (en_q) begin
            en_q      <= i_stall;
            held_stat <= out_stat;
        end
    end

    assign o_inst1 = {held_inst[0], out_stat[0]};
    assign o_inst2 = {held_inst[1], out_stat[1]};
    assign o_inst3 = {held_inst[2], out_stat[2]};
    assign o_inst4 = {held_inst[3], out_stat[3]};

endmodule
